rftpu_runtime_monitor: RTL and testbench
========================================

Name: rftpu_runtime_monitor

Overview:
Synthesizable, always-on protocol monitor for the RFTPU tile array and NoC. It is the silicon successor to the formal-only property set: the same tile-FSM, destination and latency invariants, but checked at runtime. Violations are latched into sticky, maskable error flags with first-error capture and an interrupt. It sits beside the accelerator top, snooping tile control and NoC inject/eject strobes, and is read by the host CSR block.

Parameters:
TILE_COUNT, 16, number of monitored tiles (2..64)
DST_W, 6, width of each NoC destination field (must be >= clog2(TILE_COUNT))
BUSY_TIMEOUT, 32, max cycles a tile may remain busy before a timeout error
NOC_LATENCY_MAX, 32, max cycles a destination may have outstanding packets with no eject
OUT_W, 4, width of per-destination outstanding-packet counter
CNT_WIDTH, 16, width of saturating error-event counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
tile_start  in  TILE_COUNT  per-tile start pulse
tile_busy  in  TILE_COUNT  per-tile busy level
tile_done  in  TILE_COUNT  per-tile done pulse
tile_idle  in  TILE_COUNT  per-tile idle level
noc_inject_valid  in  TILE_COUNT  packet injected by source tile t
noc_dst_tile  in  TILE_COUNT*DST_W  flattened destination, slice t = [t*DST_W +: DST_W]
noc_eject_valid  in  TILE_COUNT  packet ejected at tile t
err_mask  in  8  irq enable per error code
err_clr  in  1  clear flags, first-capture and counter
err_flags  out  8  sticky error bits, index = error code
err_first_valid  out  1  first-error capture is valid
err_first_code  out  3  code of first error
err_first_tile  out  clog2(TILE_COUNT)  tile of first error
err_count  out  CNT_WIDTH  saturating count of cycles with >=1 new error
err_first_cycle  out  32  cycle stamp of first error (optional feature)
irq  out  1  |(err_flags & err_mask), registered

Behaviour:
- Reset: all outputs 0. Shadow FSMs IDLE. Watchdogs, outstanding counters, age counters and cycle counter 0.
- Error codes: 0 STATE_MUTEX (idle&&busy), 1 START_WHILE_BUSY, 2 BUSY_TIMEOUT, 3 DONE_WITHOUT_BUSY, 4 BAD_DEST (inject with dst >= TILE_COUNT), 5 NOC_TIMEOUT, 6 EJECT_UNDERFLOW, 7 OUTSTANDING_OVF.
- Per-tile shadow FSM, states IDLE/BUSY, watchdog wd:
  - IDLE: start -> BUSY, wd=0. done without start -> code 3. start+done same cycle -> code 3, go BUSY.
  - BUSY: done -> IDLE. start without done -> code 1, stay BUSY, wd not reset. start+done same cycle -> legal back-to-back, stay BUSY, wd=0. Otherwise wd++; when wd == BUSY_TIMEOUT-1 and no done -> code 2, go IDLE (one report per operation).
  - Code 0 checked every cycle, independent of FSM.
- NoC, per destination d:
  - inc = number of valid sources with dst==d this cycle (popcount), dec = eject_valid[d].
  - out_next = out + inc - dec.
  - dec with out+inc == 0 -> code 6, out stays 0.
  - Result > 2^OUT_W-1 -> code 7, saturate at max.
  - Bad-dest injects are not counted.
  - age: 0 when out_next==0 or dec; else age+1. age reaching NOC_LATENCY_MAX -> code 5, age reset to 0 (re-fires every NOC_LATENCY_MAX cycles while stuck).
- Error detection is combinational on registered state. All outputs update on the cycle after the offending input edge (latency 1).
- First capture: when !err_first_valid and any new error occurs, latch the lowest code and, within that code, the lowest tile index (destination index for codes 5-7, source for 4).
- err_count increments by 1 per cycle with any new error, saturating at all-ones.
- err_clr: clears flags, first capture and count. Errors in the same cycle are recorded after the clear (set wins). Shadow FSMs and NoC counters are not cleared by err_clr.
- irq: registered, so one cycle after the flag.

Optional Feature:
RFTPU_MON_CYCLESTAMP_EN: when defined, a free-running 32-bit cycle counter (reset 0, wraps) runs and its value is latched into err_first_cycle with the first capture; err_clr zeroes the latch. When undefined, there is no counter and err_first_cycle is tied to 0.

Test Plan:
1. Tile 3 start, done 10 cycles later -> no flags, err_count=0, irq=0.
2. Tile 5 start, no done for 32 cycles -> err_flags[2]=1, first code=2, tile=5, err_count=1. With err_mask=8'h04, irq=1 one cycle later.
3. Same cycle: tile 2 idle&&busy, tile 7 done while IDLE -> flags 8'h09, first code=0, tile=2, err_count=1.
4. Tiles 0 and 1 inject to dst 4 in one cycle, then one eject at 4 -> out[4]=1. Eject after 32 cycles -> flag bit5 set. Extra eject with out=0 -> bit6 set.
5. Tile 9 inject with dst=20 (TILE_COUNT=16) -> bit4, first tile=9, out counters unchanged. err_clr pulsed in the same cycle as a new code-1 event -> flags=8'h02, err_count=1.
6. With RFTPU_MON_CYCLESTAMP_EN: first error at cycle 100 after reset -> err_first_cycle=100. Without the macro -> 0.

Source files
------------

// File: rtl/rftpu_runtime_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rftpu_runtime_monitor
// Purpose  : Always-on protocol monitor for the RFTPU tile array and NoC.
//            Tracks a shadow IDLE/BUSY FSM with a busy watchdog per tile,
//            and a per-destination outstanding-packet counter with an age
//            timer. Violations set sticky error flags. The monitor also
//            captures the first error, keeps a saturating event count and
//            raises a maskable registered interrupt.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            tile_start/busy/done/idle_i   per-tile control snoop
//            noc_inject_valid_i, noc_dst_tile_i, noc_eject_valid_i  NoC snoop
//            err_mask_i, err_clr_i    irq enables, clear of error state
//            err_flags_o              sticky flags, bit index = error code
//            err_first_*_o            first-error capture
//            err_count_o              saturating count of erroring cycles
//            irq_o                    |(flags & mask), one cycle after flag
// Option   : RFTPU_MON_CYCLESTAMP_EN  adds a free-running 32-bit cycle
//            counter that is latched into err_first_cycle_o. Without this
//            macro, err_first_cycle_o is tied to 0.
// Error codes: 0 STATE_MUTEX, 1 START_WHILE_BUSY, 2 BUSY_TIMEOUT,
//            3 DONE_WITHOUT_BUSY, 4 BAD_DEST, 5 NOC_TIMEOUT,
//            6 EJECT_UNDERFLOW, 7 OUTSTANDING_OVF
// Revision : 1.0  initial release
// ============================================================================
module rftpu_runtime_monitor #(
    parameter int TILE_COUNT      = 16,
    parameter int DST_W           = 6,
    parameter int BUSY_TIMEOUT    = 32,
    parameter int NOC_LATENCY_MAX = 32,
    parameter int OUT_W           = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TILE_COUNT-1:0]         tile_start_i,
    input  logic [TILE_COUNT-1:0]         tile_busy_i,
    input  logic [TILE_COUNT-1:0]         tile_done_i,
    input  logic [TILE_COUNT-1:0]         tile_idle_i,
    input  logic [TILE_COUNT-1:0]         noc_inject_valid_i,
    input  logic [TILE_COUNT*DST_W-1:0]   noc_dst_tile_i,
    input  logic [TILE_COUNT-1:0]         noc_eject_valid_i,
    input  logic [7:0]                    err_mask_i,
    input  logic                          err_clr_i,
    output logic [7:0]                    err_flags_o,
    output logic                          err_first_valid_o,
    output logic [2:0]                    err_first_code_o,
    output logic [$clog2(TILE_COUNT)-1:0] err_first_tile_o,
    output logic [CNT_WIDTH-1:0]          err_count_o,
    output logic [31:0]                   err_first_cycle_o,
    output logic                          irq_o
);

    localparam int TILE_W  = $clog2(TILE_COUNT);
    localparam int WD_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam int AGE_W   = $clog2(NOC_LATENCY_MAX + 1);
    localparam int INC_W   = $clog2(TILE_COUNT + 1);
    localparam int SUM_W   = OUT_W + INC_W + 1;
    localparam int OUT_MAX = (1 << OUT_W) - 1;

    // Destination bound, one bit wider than a dst field so that
    // TILE_COUNT itself is representable in the comparison.
    localparam logic [DST_W:0] TC_EXT = (DST_W + 1)'(TILE_COUNT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tile_state_e;

    // ------------------------------------------------------------------
    // Per-tile shadow FSM and watchdog
    // ------------------------------------------------------------------
    tile_state_e           state_q [TILE_COUNT];
    tile_state_e           state_d [TILE_COUNT];
    logic [WD_W-1:0]       wd_q    [TILE_COUNT];
    logic [WD_W-1:0]       wd_d    [TILE_COUNT];

    logic [TILE_COUNT-1:0] e_mutex;
    logic [TILE_COUNT-1:0] e_start_busy;
    logic [TILE_COUNT-1:0] e_busy_to;
    logic [TILE_COUNT-1:0] e_done_idle;

    always_comb begin
        e_mutex      = '0;
        e_start_busy = '0;
        e_busy_to    = '0;
        e_done_idle  = '0;
        for (int t = 0; t < TILE_COUNT; t++) begin
            state_d[t] = state_q[t];
            wd_d[t]    = wd_q[t];
            e_mutex[t] = tile_idle_i[t] && tile_busy_i[t];
            case (state_q[t])
                ST_IDLE: begin
                    // A done seen in IDLE is illegal even if a start
                    // arrives alongside it; the start is still honoured.
                    if (tile_done_i[t]) begin
                        e_done_idle[t] = 1'b1;
                    end
                    if (tile_start_i[t]) begin
                        state_d[t] = ST_BUSY;
                        wd_d[t]    = '0;
                    end
                end
                ST_BUSY: begin
                    if (tile_start_i[t] && tile_done_i[t]) begin
                        // Back-to-back operation: restart the watchdog.
                        wd_d[t] = '0;
                    end else if (tile_done_i[t]) begin
                        state_d[t] = ST_IDLE;
                        wd_d[t]    = '0;
                    end else begin
                        // A stray start does not restart the watchdog, so
                        // a tile cannot hide a hang by re-issuing starts.
                        if (tile_start_i[t]) begin
                            e_start_busy[t] = 1'b1;
                        end
                        if (wd_q[t] == WD_W'(BUSY_TIMEOUT - 1)) begin
                            e_busy_to[t] = 1'b1;
                            state_d[t]   = ST_IDLE;
                            wd_d[t]      = '0;
                        end else begin
                            wd_d[t] = wd_q[t] + WD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[t] = ST_IDLE;
                    wd_d[t]    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // NoC outstanding counters and age timers, per destination
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]      out_q [TILE_COUNT];
    logic [OUT_W-1:0]      out_d [TILE_COUNT];
    logic [AGE_W-1:0]      age_q [TILE_COUNT];
    logic [AGE_W-1:0]      age_d [TILE_COUNT];

    logic [TILE_COUNT-1:0] e_bad_dst;
    logic [TILE_COUNT-1:0] e_noc_to;
    logic [TILE_COUNT-1:0] e_underflow;
    logic [TILE_COUNT-1:0] e_ovf;

    always_comb begin : noc_comb
        logic [DST_W-1:0] dst;
        logic [INC_W-1:0] inc;
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] nxt;
        dst         = '0;
        inc         = '0;
        sum         = '0;
        nxt         = '0;
        e_bad_dst   = '0;
        e_noc_to    = '0;
        e_underflow = '0;
        e_ovf       = '0;
        for (int s = 0; s < TILE_COUNT; s++) begin
            dst          = noc_dst_tile_i[s*DST_W +: DST_W];
            e_bad_dst[s] = noc_inject_valid_i[s] && ({1'b0, dst} >= TC_EXT);
        end
        for (int d = 0; d < TILE_COUNT; d++) begin
            // Only in-range destinations can match d, so bad-dest injects
            // never reach a counter.
            inc = '0;
            for (int s = 0; s < TILE_COUNT; s++) begin
                dst = noc_dst_tile_i[s*DST_W +: DST_W];
                if (noc_inject_valid_i[s] && (dst == DST_W'(d))) begin
                    inc = inc + INC_W'(1);
                end
            end
            sum = SUM_W'(out_q[d]) + SUM_W'(inc);
            nxt = sum;
            if (noc_eject_valid_i[d]) begin
                if (sum == '0) begin
                    e_underflow[d] = 1'b1;
                end else begin
                    nxt = sum - SUM_W'(1);
                end
            end
            if (nxt > SUM_W'(OUT_MAX)) begin
                e_ovf[d] = 1'b1;
                nxt      = SUM_W'(OUT_MAX);
            end
            out_d[d] = nxt[OUT_W-1:0];

            // Any eject counts as forward progress for this destination.
            if ((nxt == '0) || noc_eject_valid_i[d]) begin
                age_d[d] = '0;
            end else if (age_q[d] == AGE_W'(NOC_LATENCY_MAX - 1)) begin
                e_noc_to[d] = 1'b1;
                age_d[d]    = '0;
            end else begin
                age_d[d] = age_q[d] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < TILE_COUNT; i++) begin
            if (rst) begin
                state_q[i] <= ST_IDLE;
                wd_q[i]    <= '0;
                out_q[i]   <= '0;
                age_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                wd_q[i]    <= wd_d[i];
                out_q[i]   <= out_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error aggregation, first capture, counter and irq
    // ------------------------------------------------------------------
    logic [TILE_COUNT-1:0] err_vec [8];
    logic [7:0]            new_err;
    logic                  any_err;
    logic [2:0]            first_code;
    logic [TILE_W-1:0]     first_tile;

    always_comb begin : agg_comb
        logic found_c;
        logic found_t;
        err_vec[0] = e_mutex;
        err_vec[1] = e_start_busy;
        err_vec[2] = e_busy_to;
        err_vec[3] = e_done_idle;
        err_vec[4] = e_bad_dst;
        err_vec[5] = e_noc_to;
        err_vec[6] = e_underflow;
        err_vec[7] = e_ovf;
        found_c    = 1'b0;
        found_t    = 1'b0;
        first_code = '0;
        first_tile = '0;
        for (int c = 0; c < 8; c++) begin
            new_err[c] = |err_vec[c];
        end
        any_err = |new_err;
        for (int c = 0; c < 8; c++) begin
            if (!found_c && new_err[c]) begin
                found_c    = 1'b1;
                first_code = 3'(c);
            end
        end
        for (int t = 0; t < TILE_COUNT; t++) begin
            if (!found_t && err_vec[first_code][t]) begin
                found_t    = 1'b1;
                first_tile = TILE_W'(t);
            end
        end
    end

    logic [7:0]           flags_q,       flags_d;
    logic                 first_valid_q, first_valid_d;
    logic [2:0]           first_code_q,  first_code_d;
    logic [TILE_W-1:0]    first_tile_q,  first_tile_d;
    logic [CNT_WIDTH-1:0] count_q,       count_d;
    logic                 irq_q,         irq_d;

    always_comb begin : state_comb
        logic [CNT_WIDTH-1:0] cnt_base;
        // Clear applies first so errors in the clear cycle are kept.
        flags_d       = (err_clr_i ? 8'h00 : flags_q) | new_err;
        first_valid_d = err_clr_i ? 1'b0 : first_valid_q;
        first_code_d  = err_clr_i ? 3'd0 : first_code_q;
        first_tile_d  = err_clr_i ? '0   : first_tile_q;
        if (!first_valid_d && any_err) begin
            first_valid_d = 1'b1;
            first_code_d  = first_code;
            first_tile_d  = first_tile;
        end
        cnt_base = err_clr_i ? '0 : count_q;
        count_d  = (any_err && (cnt_base != '1)) ? cnt_base + CNT_WIDTH'(1) : cnt_base;
        irq_d    = |(flags_q & err_mask_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q       <= '0;
            first_valid_q <= 1'b0;
            first_code_q  <= '0;
            first_tile_q  <= '0;
            count_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            first_valid_q <= first_valid_d;
            first_code_q  <= first_code_d;
            first_tile_q  <= first_tile_d;
            count_q       <= count_d;
            irq_q         <= irq_d;
        end
    end

`ifdef RFTPU_MON_CYCLESTAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] first_cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q         <= '0;
            first_cycle_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (!(first_valid_q && !err_clr_i) && any_err) begin
                first_cycle_q <= cyc_q;
            end else if (err_clr_i) begin
                first_cycle_q <= '0;
            end
        end
    end

    assign err_first_cycle_o = first_cycle_q;
`else
    assign err_first_cycle_o = 32'd0;
`endif

    assign err_flags_o       = flags_q;
    assign err_first_valid_o = first_valid_q;
    assign err_first_code_o  = first_code_q;
    assign err_first_tile_o  = first_tile_q;
    assign err_count_o       = count_q;
    assign irq_o             = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_rftpu_runtime_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rftpu_runtime_monitor
// Purpose  : Directed self-checking bench for rftpu_runtime_monitor. Inputs
//            change 1 time unit after a rising edge. Outputs are sampled at
//            the same point, so each step observes the edge just taken.
// Revision : 1.0  initial release
// ============================================================================
module tb_rftpu_runtime_monitor;

    localparam int TILE_COUNT = 16;
    localparam int DST_W      = 6;
    localparam int CNT_WIDTH  = 16;

    logic                        clk;
    logic                        rst;
    logic [TILE_COUNT-1:0]       tile_start_i;
    logic [TILE_COUNT-1:0]       tile_busy_i;
    logic [TILE_COUNT-1:0]       tile_done_i;
    logic [TILE_COUNT-1:0]       tile_idle_i;
    logic [TILE_COUNT-1:0]       noc_inject_valid_i;
    logic [TILE_COUNT*DST_W-1:0] noc_dst_tile_i;
    logic [TILE_COUNT-1:0]       noc_eject_valid_i;
    logic [7:0]                  err_mask_i;
    logic                        err_clr_i;
    logic [7:0]                  err_flags_o;
    logic                        err_first_valid_o;
    logic [2:0]                  err_first_code_o;
    logic [3:0]                  err_first_tile_o;
    logic [CNT_WIDTH-1:0]        err_count_o;
    logic [31:0]                 err_first_cycle_o;
    logic                        irq_o;

    int checks = 0;
    int errors = 0;
    int n_cyc  = 0;
    int stamp  = 0;

    rftpu_runtime_monitor dut (
        .clk                (clk),
        .rst                (rst),
        .tile_start_i       (tile_start_i),
        .tile_busy_i        (tile_busy_i),
        .tile_done_i        (tile_done_i),
        .tile_idle_i        (tile_idle_i),
        .noc_inject_valid_i (noc_inject_valid_i),
        .noc_dst_tile_i     (noc_dst_tile_i),
        .noc_eject_valid_i  (noc_eject_valid_i),
        .err_mask_i         (err_mask_i),
        .err_clr_i          (err_clr_i),
        .err_flags_o        (err_flags_o),
        .err_first_valid_o  (err_first_valid_o),
        .err_first_code_o   (err_first_code_o),
        .err_first_tile_o   (err_first_tile_o),
        .err_count_o        (err_count_o),
        .err_first_cycle_o  (err_first_cycle_o),
        .irq_o              (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_stamp(input int s);
`ifdef RFTPU_MON_CYCLESTAMP_EN
        return 32'(s);
`else
        return 32'd0 + 32'(s & 0);
`endif
    endfunction

    task automatic clear_errs();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        tile_start_i       = '0;
        tile_busy_i        = '0;
        tile_done_i        = '0;
        tile_idle_i        = '0;
        noc_inject_valid_i = '0;
        noc_dst_tile_i     = '0;
        noc_eject_valid_i  = '0;
        err_mask_i         = '0;
        err_clr_i          = 1'b0;

        // Reset state
        repeat (3) step();
        check_eq("rst_flags", 32'(err_flags_o), 32'h00);
        check_eq("rst_valid", 32'(err_first_valid_o), 32'd0);
        check_eq("rst_count", 32'(err_count_o), 32'd0);
        check_eq("rst_irq", 32'(irq_o), 32'd0);
        check_eq("rst_cycle", err_first_cycle_o, 32'd0);
        rst   = 1'b0;
        n_cyc = 0;

        // 1: tile 3 clean operation, done 10 cycles after start
        tile_start_i[3] = 1'b1;
        step();
        tile_start_i[3] = 1'b0;
        tile_busy_i[3]  = 1'b1;
        repeat (9) step();
        tile_busy_i[3] = 1'b0;
        tile_done_i[3] = 1'b1;
        step();
        tile_done_i[3] = 1'b0;
        step();
        check_eq("t1_flags", 32'(err_flags_o), 32'h00);
        check_eq("t1_count", 32'(err_count_o), 32'd0);
        check_eq("t1_irq", 32'(irq_o), 32'd0);

        // Pad so the next (first) error occurs at cycle 100
        while (n_cyc < 100) step();

        // 3: tile 2 idle&busy and tile 7 done while IDLE in one cycle
        tile_idle_i[2] = 1'b1;
        tile_busy_i[2] = 1'b1;
        tile_done_i[7] = 1'b1;
        stamp = n_cyc;
        step();
        tile_idle_i[2] = 1'b0;
        tile_busy_i[2] = 1'b0;
        tile_done_i[7] = 1'b0;
        check_eq("t3_flags", 32'(err_flags_o), 32'h09);
        check_eq("t3_valid", 32'(err_first_valid_o), 32'd1);
        check_eq("t3_code", 32'(err_first_code_o), 32'd0);
        check_eq("t3_tile", 32'(err_first_tile_o), 32'd2);
        check_eq("t3_count", 32'(err_count_o), 32'd1);
        check_eq("t3_cycle", err_first_cycle_o, exp_stamp(100));
        step();
        check_eq("t3_count_hold", 32'(err_count_o), 32'd1);
        clear_errs();
        check_eq("clr_flags", 32'(err_flags_o), 32'h00);
        check_eq("clr_valid", 32'(err_first_valid_o), 32'd0);
        check_eq("clr_count", 32'(err_count_o), 32'd0);
        check_eq("clr_cycle", err_first_cycle_o, 32'd0);

        // 2: tile 5 busy timeout, irq via mask bit 2
        err_mask_i      = 8'h04;
        tile_start_i[5] = 1'b1;
        step();
        tile_start_i[5] = 1'b0;
        tile_busy_i[5]  = 1'b1;
        repeat (31) step();
        check_eq("t2_flags_early", 32'(err_flags_o), 32'h00);
        stamp = n_cyc;
        step();
        tile_busy_i[5] = 1'b0;
        check_eq("t2_flags", 32'(err_flags_o), 32'h04);
        check_eq("t2_code", 32'(err_first_code_o), 32'd2);
        check_eq("t2_tile", 32'(err_first_tile_o), 32'd5);
        check_eq("t2_count", 32'(err_count_o), 32'd1);
        check_eq("t2_cycle", err_first_cycle_o, exp_stamp(stamp));
        check_eq("t2_irq_lag", 32'(irq_o), 32'd0);
        step();
        check_eq("t2_irq", 32'(irq_o), 32'd1);
        clear_errs();
        step();
        check_eq("t2_irq_off", 32'(irq_o), 32'd0);
        err_mask_i = 8'h00;

        // 4: two injects to dst 4, one eject, then timeout and underflow
        noc_inject_valid_i[0] = 1'b1;
        noc_inject_valid_i[1] = 1'b1;
        noc_dst_tile_i[0*DST_W +: DST_W] = 6'd4;
        noc_dst_tile_i[1*DST_W +: DST_W] = 6'd4;
        step();
        noc_inject_valid_i   = '0;
        noc_eject_valid_i[4] = 1'b1;
        step();
        noc_eject_valid_i[4] = 1'b0;
        check_eq("t4_flags_ej", 32'(err_flags_o), 32'h00);
        repeat (31) step();
        check_eq("t4_flags_early", 32'(err_flags_o), 32'h00);
        step();
        check_eq("t4_noc_to", 32'(err_flags_o), 32'h20);
        check_eq("t4_code", 32'(err_first_code_o), 32'd5);
        check_eq("t4_tile", 32'(err_first_tile_o), 32'd4);
        noc_eject_valid_i[4] = 1'b1;
        step();
        check_eq("t4_last_ej", 32'(err_flags_o), 32'h20);
        step();
        noc_eject_valid_i[4] = 1'b0;
        check_eq("t4_underflow", 32'(err_flags_o), 32'h60);
        check_eq("t4_count", 32'(err_count_o), 32'd2);
        clear_errs();

        // 5: bad destination, not counted; then clear racing a new error
        noc_inject_valid_i[9] = 1'b1;
        noc_dst_tile_i[9*DST_W +: DST_W] = 6'd20;
        step();
        noc_inject_valid_i = '0;
        check_eq("t5_flags", 32'(err_flags_o), 32'h10);
        check_eq("t5_code", 32'(err_first_code_o), 32'd4);
        check_eq("t5_tile", 32'(err_first_tile_o), 32'd9);
        noc_eject_valid_i[4] = 1'b1;
        step();
        noc_eject_valid_i[4] = 1'b0;
        check_eq("t5_no_alias", 32'(err_flags_o), 32'h50);
        tile_start_i[6] = 1'b1;
        step();
        check_eq("t5_start_ok", 32'(err_flags_o), 32'h50);
        err_clr_i = 1'b1;
        step();
        err_clr_i       = 1'b0;
        tile_start_i[6] = 1'b0;
        check_eq("t5_clr_flags", 32'(err_flags_o), 32'h02);
        check_eq("t5_clr_count", 32'(err_count_o), 32'd1);
        check_eq("t5_clr_code", 32'(err_first_code_o), 32'd1);
        check_eq("t5_clr_tile", 32'(err_first_tile_o), 32'd6);
        tile_done_i[6] = 1'b1;
        step();
        tile_done_i[6] = 1'b0;
        step();
        check_eq("t5_done", 32'(err_flags_o), 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
